merge_rr5: RTL and testbench
============================

# merge_rr5

Five-channel round-robin merger with packet lock and a registered output stage. It sits directly downstream of the 1-to-5 demultiplexer stage and recombines its five outputs `b`..`f` (channels 0..4) into a single valid/ready stream. Each output beat is tagged with its source channel index. Arbitration is fair at packet granularity: once a channel wins, it keeps the output until its `last` beat.

## Interface
- `WIDTH`, default 32: data width per channel.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 5: per-channel valid; bit i is channel i (0=b, 1=c, 2=d, 3=e, 4=f).
- `in_last` input 5: per-channel end-of-packet flag, qualified by `in_valid`.
- `in_data` input 5*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready` output 5: per-channel ready; at most one bit is set in any cycle.
- `out_valid` output 1: registered output valid.
- `out_data` output WIDTH: registered output data.
- `out_last` output 1: registered end-of-packet flag.
- `out_src` output 3: registered source channel index, range 0..4.
- `out_ready` input 1: downstream ready.

## Operation
- Transfer definitions:
  - Input transfer on channel i: `in_valid[i] & in_ready[i]`.
  - Output transfer: `out_valid & out_ready`.
- Load enable: `load_en = !out_valid | out_ready`. The output register accepts a new beat only when `load_en` is high.
- State:
  - `ptr`: 3 bits, range 0..4, the priority start point.
  - `state`: IDLE or LOCKED.
  - `lock_ch`: 3 bits, the channel holding the lock.
- Arbitration in IDLE:
  - The candidate is the first channel with `in_valid` set, scanning `ptr`, `ptr+1`, ... modulo 5.
  - With no valid channel there is no candidate and `in_ready` is 0.
- Arbitration in LOCKED: the candidate is `lock_ch` only. All other channels have `in_ready` = 0 even if valid.
- `in_ready[cand] = load_en & in_valid[cand]`. `in_ready` is combinational from `in_valid`, `out_ready` and state. No other path to `in_ready` exists.
- On an input transfer from channel k:
  - The output register loads `out_data` = channel k data, `out_last` = `in_last[k]`, `out_src` = k, and sets `out_valid` = 1.
  - If `in_last[k]` = 1: `state` goes to IDLE and `ptr` becomes (k+1) mod 5. Wrap: k=4 gives `ptr`=0.
  - If `in_last[k]` = 0: `state` goes to LOCKED with `lock_ch` = k, and `ptr` is unchanged.
- When an output transfer happens with no input transfer in the same cycle, `out_valid` clears. Data fields hold their last value.
- Simultaneous output transfer and input transfer: the register is overwritten with the new beat and `out_valid` stays 1, giving full throughput of one beat per cycle.
- The lock persists indefinitely while the locked channel is idle. There is no timeout and no preemption.
- `ptr` values 5..7 are unreachable. If one is ever present, it is treated as 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `ptr`=0, `state`=IDLE, `lock_ch`=0. `in_ready` is therefore 0 while `rst_n` is low.
- Latency: an input transfer in cycle N appears on the outputs in cycle N+1.
- Throughput: 1 beat per cycle when `out_ready` is held high.
- Backpressure: with `out_valid`=1 and `out_ready`=0, all `in_ready` bits are 0 and the outputs are stable.
- Reset asserted mid-packet: immediate return to the reset values above, and the lock is dropped. No partial state survives reset.
- Single-beat packet (`last`=1 on the first beat): no lock is taken and arbitration advances the same cycle.

## Test plan
- Reset, then all five channels valid with `last`=1 and `out_ready`=1 → `out_src` sequence 0,1,2,3,4,0 on consecutive cycles; first `out_valid` one cycle after the first accept.
- Channel 2 sends a 3-beat packet (`last` on beat 3) while channels 0 and 4 are valid → `out_src` = 2,2,2,4,0; `in_ready[0]` and `in_ready[4]` stay 0 during the packet.
- Channel 4 is the only valid channel, sends a single beat → `ptr` wraps to 0; next with channels 0 and 3 valid → channel 0 granted first.
- `out_ready`=0 for 4 cycles with a beat held (data 0xA5A5A5A5) → `out_data` stable, all `in_ready`=0. Release → exactly one output transfer, and a new input transfer in the same cycle.
- Locked on channel 1 after beat 1; channel 1 drops valid for 3 cycles while channel 3 is valid → no grant to channel 3; channel 1 resumes with `last` → channel 3 is granted next.
- Assert `rst_n`=0 mid-packet with the lock on channel 2 → `out_valid`=0 immediately. After release with channels 0 and 2 valid → channel 0 is granted (`ptr`=0, IDLE).

Source files
------------

// File: rtl/merge_rr5.sv
`default_nettype none
// ============================================================================
// Module   : merge_rr5
// Purpose  : Five-channel round-robin merger with packet lock. Recombines
//            channels 0..4 into one valid/ready stream through a single
//            registered output stage, tagging every beat with its source.
//            Once a channel wins, it owns the output until its last beat.
// Ports    : clk, rst_n             - clock, async active-low reset
//            in_valid/in_last [4:0] - per-channel valid and end-of-packet
//            in_data [5*WIDTH-1:0]  - channel i at [i*WIDTH +: WIDTH]
//            in_ready [4:0]         - per-channel ready (one-hot or zero)
//            out_valid/out_data/out_last/out_src - registered output beat
//            out_ready              - downstream ready
// Revision : 1.0 - initial release
// ============================================================================
module merge_rr5 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           in_valid,
    input  logic [4:0]           in_last,
    input  logic [5*WIDTH-1:0]   in_data,
    output logic [4:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [2:0]           out_src,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [2:0]       lock_ch;

    logic             load_en;
    logic [2:0]       ptr_eff;
    logic [2:0]       cand;
    logic             cand_found;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [2:0]       next_ptr;
    logic [3:0]       scan_sum;
    logic [2:0]       scan_idx;

    // The output register may take a beat when empty or draining this cycle.
    assign load_en = !out_valid || out_ready;

    // Out-of-range pointer values are treated as channel 0.
    assign ptr_eff = (ptr > 3'd4) ? 3'd0 : ptr;

    // Candidate selection. In IDLE, scan from the farthest offset down to
    // offset 0 so that the closest valid channel to ptr is the last write
    // and therefore wins.
    always_comb begin
        cand       = 3'd0;
        cand_found = 1'b0;
        scan_sum   = 4'd0;
        scan_idx   = 3'd0;
        if (state == LOCKED) begin
            cand       = lock_ch;
            cand_found = in_valid[lock_ch];
        end else begin
            for (int o = 4; o >= 0; o--) begin
                scan_sum = {1'b0, ptr_eff} + 4'(o);
                scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : scan_sum[2:0];
                if (in_valid[scan_idx]) begin
                    cand       = scan_idx;
                    cand_found = 1'b1;
                end
            end
        end
    end

    // Reset gating keeps in_ready low while rst_n is asserted even though
    // the empty output register would otherwise allow a load.
    assign xfer = rst_n && cand_found && load_en;

    always_comb begin
        in_ready = 5'd0;
        if (xfer) begin
            in_ready[cand] = 1'b1;
        end
    end

    // Mux the winning channel's payload.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (cand == 3'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    assign next_ptr = (cand >= 3'd4) ? 3'd0 : cand + 3'd1;

    // Arbitration state and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            lock_ch   <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 3'd0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= cand;
                if (sel_last) begin
                    // Packet complete: release and advance past the winner.
                    state <= IDLE;
                    ptr   <= next_ptr;
                end else begin
                    // Hold the output for this channel; ptr stays put.
                    state   <= LOCKED;
                    lock_ch <= cand;
                end
            end else if (out_valid && out_ready) begin
                // Drained with nothing to replace it; payload is held.
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_merge_rr5.sv
`default_nettype none
// ============================================================================
// Module   : tb_merge_rr5
// Purpose  : Directed self-checking bench for merge_rr5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_merge_rr5;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst_n;
    logic [4:0]         in_valid;
    logic [4:0]         in_last;
    logic [5*WIDTH-1:0] in_data;
    logic [4:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [2:0]         out_src;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    merge_rr5 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [31:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        logic [2:0] exp_src [6];
        exp_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        in_valid  = 5'h1F;
        in_last   = 5'h1F;
        out_ready = 1'b1;
        in_data   = '0;
        for (int i = 0; i < 5; i++) set_data(i, 32'h1000_0000 + i);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_src",   32'(out_src),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);

        // ---------------- round robin, single-beat packets ----------------
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'h01);
        chk("rr_no_valid_yet", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_src",   32'(out_src),   32'(exp_src[k]));
            chk("rr_data",  out_data,       32'h1000_0000 + 32'(exp_src[k]));
        end
        in_valid = 5'd0;
        step();
        chk("rr_drain_valid", 32'(out_valid), 32'd0);
        chk("rr_hold_data",   out_data,       32'h1000_0000);

        // ---------------- channel 2 three-beat packet (ptr = 1) ----------------
        in_last  = 5'b10001;
        in_valid = 5'b10101;
        #1;
        chk("pk_ready_b1", 32'(in_ready), 32'h04);
        step();
        chk("pk_src_b1",  32'(out_src),  32'd2);
        chk("pk_last_b1", 32'(out_last), 32'd0);
        chk("pk_ready_b2", 32'(in_ready), 32'h04);
        step();
        chk("pk_src_b2",  32'(out_src),  32'd2);
        in_last[2] = 1'b1;
        #1;
        chk("pk_ready_b3", 32'(in_ready), 32'h04);
        step();
        chk("pk_src_b3",  32'(out_src),  32'd2);
        chk("pk_last_b3", 32'(out_last), 32'd1);
        in_valid = 5'b10001;
        #1;
        chk("pk_ready_ch4", 32'(in_ready), 32'h10);
        step();
        chk("pk_src_ch4", 32'(out_src), 32'd4);
        chk("pk_ready_ch0", 32'(in_ready), 32'h01);
        step();
        chk("pk_src_ch0", 32'(out_src), 32'd0);
        in_valid = 5'd0;
        step();
        chk("pk_drain", 32'(out_valid), 32'd0);

        // ---------------- ch4 single beat, pointer wrap (ptr = 1) ----------------
        in_last  = 5'h1F;
        in_valid = 5'b10000;
        step();
        chk("wr_src4", 32'(out_src), 32'd4);
        in_valid = 5'b01001;
        #1;
        chk("wr_ready0", 32'(in_ready), 32'h01);
        step();
        chk("wr_src0", 32'(out_src), 32'd0);
        in_valid = 5'd0;
        step();

        // ---------------- backpressure (ptr = 1) ----------------
        out_ready = 1'b0;
        set_data(1, 32'hA5A5_A5A5);
        in_valid = 5'b00010;
        #1;
        chk("bp_ready_empty", 32'(in_ready), 32'h02);
        step();
        chk("bp_loaded", out_data, 32'hA5A5_A5A5);
        set_data(1, 32'h1234_5678);
        for (int c = 0; c < 4; c++) begin
            chk("bp_ready_blocked", 32'(in_ready), 32'd0);
            step();
            chk("bp_data_stable",  out_data,        32'hA5A5_A5A5);
            chk("bp_valid_stable", 32'(out_valid),  32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h02);
        step();
        chk("bp_new_data",  out_data,       32'h1234_5678);
        chk("bp_new_valid", 32'(out_valid), 32'd1);
        in_valid = 5'd0;
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // ---------------- lock on ch1 with idle gaps (ptr = 2) ----------------
        in_last  = 5'b11101;
        in_valid = 5'b00010;
        step();
        chk("lk_src1", 32'(out_src), 32'd1);
        in_valid = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lk_ready_blocked", 32'(in_ready), 32'd0);
            step();
            chk("lk_no_output", 32'(out_valid), 32'd0);
        end
        in_last  = 5'h1F;
        in_valid = 5'b01010;
        #1;
        chk("lk_resume_ready", 32'(in_ready), 32'h02);
        step();
        chk("lk_src1_last", 32'(out_src), 32'd1);
        in_valid = 5'b01000;
        #1;
        chk("lk_ch3_ready", 32'(in_ready), 32'h08);
        step();
        chk("lk_src3", 32'(out_src), 32'd3);
        in_valid = 5'd0;
        step();

        // ---------------- reset mid-packet, lock on ch2 (ptr = 4) ----------------
        in_last  = 5'b11011;
        in_valid = 5'b00100;
        #1;
        chk("rm_ready2", 32'(in_ready), 32'h04);
        step();
        chk("rm_src2", 32'(out_src), 32'd2);
        in_valid = 5'b00101;
        step();
        chk("rm_locked_src2", 32'(out_src), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_valid_cleared", 32'(out_valid), 32'd0);
        chk("rm_ready_cleared", 32'(in_ready),  32'd0);
        chk("rm_src_cleared",   32'(out_src),   32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        in_last = 5'h1F;
        #1;
        chk("rm_post_ready", 32'(in_ready), 32'h01);
        step();
        chk("rm_post_src", 32'(out_src), 32'd0);
        chk("rm_post_valid", 32'(out_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
